// File: rtl/sdram_cmd_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_cmd_sched_if
// Description : Command/data bus between the SDRAM command scheduler and the
//               SDRAM_16bit controller. The master is the scheduler, which
//               issues commands; the slave is the controller, which acks them
//               and strobes the data beats.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_cmd_sched_if;
  logic [1:0]  sys_cmd;
  logic [17:0] sys_addr;
  logic [1:0]  sys_cmd_ack;
  logic        sys_rd_data_valid;
  logic        sys_wr_data_valid;
  logic [15:0] sys_dout;

  modport master (
    output sys_cmd, sys_addr,
    input  sys_cmd_ack, sys_rd_data_valid, sys_wr_data_valid, sys_dout
  );

  modport slave (
    input  sys_cmd, sys_addr,
    output sys_cmd_ack, sys_rd_data_valid, sys_wr_data_valid, sys_dout
  );
endinterface
`default_nettype wire

// File: rtl/sdram_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : sdram_cmd_sched
// Description : Arbitrates video refill, cache write-back and cache fill
//               requests onto the SDRAM controller. Holds each command until
//               acked, counts beats to find the burst end, packs video read
//               beats into 32-bit words and owns the wrapping video address.
//               Optional macro SDR_FAIRNESS_EN bounds consecutive video
//               grants while a cache request waits.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_cmd_sched #(
  parameter int VID_BURSTS = 3072,
  parameter int VID_BEATS  = 16,
  parameter int LINE_BEATS = 128,
  parameter int MAX_VID    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  sdram_cmd_sched_if.master        sys,
  input  logic                     vid_need,
  input  logic                     vid_restart,
  input  logic                     cache_wr_req,
  input  logic                     cache_rd_req,
  input  logic [11:0]              wb_addr,
  input  logic [11:0]              fill_addr,
  output logic                     cache_wdata_en,
  output logic                     cache_rdata_en,
  output logic [31:0]              vq_data,
  output logic                     vq_wr,
  output logic [11:0]              vid_addr,
  output logic                     busy
);

  localparam logic [1:0] c_CMD_NOP   = 2'b00;
  localparam logic [1:0] c_CMD_WR    = 2'b01;
  localparam logic [1:0] c_CMD_RD32  = 2'b10;
  localparam logic [1:0] c_CMD_RD256 = 2'b11;

  localparam int c_MAX_BEATS = (VID_BEATS > LINE_BEATS) ? VID_BEATS : LINE_BEATS;
  localparam int c_CNT_W     = $clog2(c_MAX_BEATS + 1);
  localparam logic [c_CNT_W-1:0] c_VID_LAST  = c_CNT_W'(VID_BEATS - 1);
  localparam logic [c_CNT_W-1:0] c_LINE_LAST = c_CNT_W'(LINE_BEATS - 1);
  localparam logic [11:0]        c_VID_WRAP  = 12'(VID_BURSTS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_XFER = 2'd2} state_t;
  typedef enum logic [1:0] {O_VID = 2'd0, O_WB = 2'd1, O_FILL = 2'd2} owner_t;

  state_t               r_state;
  owner_t               r_owner;
  logic [1:0]           r_sys_cmd;
  logic [17:0]          r_sys_addr;
  logic [c_CNT_W-1:0]   r_beat_cnt;
  logic                 r_half;
  logic [15:0]          r_vq_low;
  logic [31:0]          r_vq_data;
  logic                 r_vq_wr;
  logic [11:0]          r_vid_addr;
  logic                 r_restart_pend;

  logic                 w_idle;
  logic                 w_xfer;
  logic                 w_cache_pend;
  logic                 w_vid_allowed;
  logic                 w_grant_vid;
  logic                 w_grant_wb;
  logic                 w_grant_fill;
  logic                 w_vid_beat;
  logic                 w_fill_beat;
  logic                 w_wb_beat;
  logic                 w_beat;
  logic                 w_last_beat;
  logic                 w_vid_owned;
  logic [11:0]          w_vid_addr_cur;
  logic [11:0]          w_vid_addr_next;

  assign w_idle       = (r_state == S_IDLE);
  assign w_xfer       = (r_state == S_XFER);
  assign w_cache_pend = cache_wr_req | cache_rd_req;

`ifdef SDR_FAIRNESS_EN
  localparam int c_STREAK_W = $clog2(MAX_VID + 1);
  logic [c_STREAK_W-1:0] r_vid_streak;

  // Video loses its priority once it has won MAX_VID grants in a row over a waiting cache request
  assign w_vid_allowed = vid_need &
                         ~(w_cache_pend && (r_vid_streak >= c_STREAK_W'(MAX_VID)));

  // Track consecutive video grants made while the cache is kept waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vid_streak <= '0;
    end else if (!w_cache_pend) begin
      r_vid_streak <= '0;
    end else if (w_grant_vid) begin
      r_vid_streak <= r_vid_streak + 1'b1;
    end else if (w_grant_wb || w_grant_fill) begin
      r_vid_streak <= '0;
    end
  end
`else
  logic w_unused_max_vid;
  // The fairness limit has no meaning under strict priority
  assign w_unused_max_vid = (MAX_VID != 0);
  assign w_vid_allowed    = vid_need;
`endif

  assign w_grant_vid  = w_idle & w_vid_allowed;
  assign w_grant_wb   = w_idle & ~w_vid_allowed & cache_wr_req;
  assign w_grant_fill = w_idle & ~w_vid_allowed & ~cache_wr_req & cache_rd_req;

  // Only beats of the type the current owner expects are counted or forwarded
  assign w_vid_beat   = w_xfer & (r_owner == O_VID)  & sys.sys_rd_data_valid;
  assign w_fill_beat  = w_xfer & (r_owner == O_FILL) & sys.sys_rd_data_valid;
  assign w_wb_beat    = w_xfer & (r_owner == O_WB)   & sys.sys_wr_data_valid;
  assign w_beat       = w_vid_beat | w_fill_beat | w_wb_beat;
  assign w_last_beat  = w_beat &
                        ((r_owner == O_VID) ? (r_beat_cnt == c_VID_LAST)
                                            : (r_beat_cnt == c_LINE_LAST));

  // A restart while video owns the bus waits for the burst to end
  assign w_vid_owned     = ~w_idle & (r_owner == O_VID);
  assign w_vid_addr_cur  = vid_restart ? 12'd0 : r_vid_addr;
  assign w_vid_addr_next = (r_vid_addr == c_VID_WRAP) ? 12'd0 : r_vid_addr + 12'd1;

  // Scheduler FSM: grant, hold command until ack, then count the burst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_owner        <= O_VID;
      r_sys_cmd      <= c_CMD_NOP;
      r_sys_addr     <= '0;
      r_beat_cnt     <= '0;
      r_half         <= 1'b0;
      r_vq_low       <= '0;
      r_vq_data      <= '0;
      r_vq_wr        <= 1'b0;
      r_vid_addr     <= '0;
      r_restart_pend <= 1'b0;
    end else begin
      r_vq_wr <= 1'b0;
      if (vid_restart && !w_vid_owned) begin
        r_vid_addr <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_grant_vid) begin
            r_sys_cmd  <= c_CMD_RD32;
            r_sys_addr <= {3'b100, w_vid_addr_cur, 3'b000};
            r_owner    <= O_VID;
            r_state    <= S_ISSUE;
          end else if (w_grant_wb) begin
            r_sys_cmd  <= c_CMD_WR;
            r_sys_addr <= {wb_addr, 6'b0};
            r_owner    <= O_WB;
            r_state    <= S_ISSUE;
          end else if (w_grant_fill) begin
            r_sys_cmd  <= c_CMD_RD256;
            r_sys_addr <= {fill_addr, 6'b0};
            r_owner    <= O_FILL;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (vid_restart && (r_owner == O_VID)) begin
            r_restart_pend <= 1'b1;
          end
          if (sys.sys_cmd_ack == r_sys_cmd) begin
            r_sys_cmd  <= c_CMD_NOP;
            r_beat_cnt <= '0;
            r_half     <= 1'b0;
            r_state    <= S_XFER;
            if (r_owner == O_VID) begin
              r_vid_addr <= w_vid_addr_next;
            end
          end
        end
        S_XFER: begin
          if (vid_restart && (r_owner == O_VID)) begin
            r_restart_pend <= 1'b1;
          end
          if (w_vid_beat) begin
            r_half <= ~r_half;
            if (!r_half) begin
              r_vq_low <= sys.sys_dout;
            end else begin
              r_vq_data <= {sys.sys_dout, r_vq_low};
              r_vq_wr   <= 1'b1;
            end
          end
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
          if (w_last_beat) begin
            r_state        <= S_IDLE;
            r_restart_pend <= 1'b0;
            if ((r_owner == O_VID) && (r_restart_pend || vid_restart)) begin
              r_vid_addr <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sys.sys_cmd     = r_sys_cmd;
  assign sys.sys_addr    = r_sys_addr;
  assign cache_wdata_en  = w_fill_beat;
  assign cache_rdata_en  = w_wb_beat;
  assign vq_data         = r_vq_data;
  assign vq_wr           = r_vq_wr;
  assign vid_addr        = r_vid_addr;
  assign busy            = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_sdram_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_cmd_sched
// Description : Self-checking bench for sdram_cmd_sched. Emulates the SDRAM
//               controller (ack delay, beats, stray strobes) and predicts
//               grants, addresses, packed video words and the frame address
//               from a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_cmd_sched;

  localparam int c_VID_BURSTS = 64;
  localparam int c_VID_BEATS  = 16;
  localparam int c_LINE_BEATS = 128;
  localparam int c_MAX_VID    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vid_need = 1'b0;
  logic        vid_restart = 1'b0;
  logic        cache_wr_req = 1'b0;
  logic        cache_rd_req = 1'b0;
  logic [11:0] wb_addr = '0;
  logic [11:0] fill_addr = '0;
  logic        cache_wdata_en;
  logic        cache_rdata_en;
  logic [31:0] vq_data;
  logic        vq_wr;
  logic [11:0] vid_addr;
  logic        busy;

  sdram_cmd_sched_if sif();

  sdram_cmd_sched #(
    .VID_BURSTS (c_VID_BURSTS),
    .VID_BEATS  (c_VID_BEATS),
    .LINE_BEATS (c_LINE_BEATS),
    .MAX_VID    (c_MAX_VID)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sys            (sif),
    .vid_need       (vid_need),
    .vid_restart    (vid_restart),
    .cache_wr_req   (cache_wr_req),
    .cache_rd_req   (cache_rd_req),
    .wb_addr        (wb_addr),
    .fill_addr      (fill_addr),
    .cache_wdata_en (cache_wdata_en),
    .cache_rdata_en (cache_rdata_en),
    .vq_data        (vq_data),
    .vq_wr          (vq_wr),
    .vid_addr       (vid_addr),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // monitor-owned pulse counters and captured video words
  int          vq_cnt = 0;
  int          cw_cnt = 0;
  int          cr_cnt = 0;
  logic [31:0] vq_got[$];

  // reference model state
  int          m_vid = 0;
  int          m_streak = 0;
  logic [31:0] vq_exp[$];

  // count output pulses mid-cycle, well away from the active edge
  always @(negedge clk) begin
    if (vq_wr === 1'b1) begin
      vq_cnt = vq_cnt + 1;
      vq_got.push_back(vq_data);
    end
    if (cache_wdata_en === 1'b1) cw_cnt = cw_cnt + 1;
    if (cache_rdata_en === 1'b1) cr_cnt = cr_cnt + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Which client should win the next grant, and the word address it targets
  task automatic predict(output logic [1:0] cmd, output logic [17:0] addr);
    bit pend;
    bit vid_ok;
    pend   = cache_wr_req | cache_rd_req;
    vid_ok = vid_need;
`ifdef SDR_FAIRNESS_EN
    if (!pend) m_streak = 0;
    if (pend && m_streak >= c_MAX_VID) vid_ok = 1'b0;
`endif
    if (vid_ok) begin
      cmd  = 2'b10;
      addr = 18'(32'h20000 + m_vid * 8);
      if (pend) m_streak++;
    end else if (cache_wr_req) begin
      cmd  = 2'b01;
      addr = 18'(int'(wb_addr) * 64);
      m_streak = 0;
    end else if (cache_rd_req) begin
      cmd  = 2'b11;
      addr = 18'(int'(fill_addr) * 64);
      m_streak = 0;
    end else begin
      cmd  = 2'b00;
      addr = '0;
    end
  endtask

  // One full transaction as the controller would run it. Requests are
  // already set; returns mid-cycle with the DUT back in IDLE.
  task automatic txn(input int ack_dly, input bit gaps, input bit seq_data,
                     input bit restart_mid, input int rst_beat);
    logic [1:0]  ecmd;
    logic [17:0] eaddr;
    logic [15:0] d;
    logic [15:0] low;
    int          waited;
    int          beats;
    int          n;
    int          vq0, cw0, cr0, q0;
    bit          stable;
    predict(ecmd, eaddr);
    vq_exp.delete();
    vq0 = vq_cnt; cw0 = cw_cnt; cr0 = cr_cnt; q0 = vq_got.size();

    waited = 0;
    @(posedge clk); #1;
    while (sif.sys_cmd == 2'b00 && waited < 6) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("grant_cmd", 32'(sif.sys_cmd), 32'(ecmd));
    chk("grant_addr", 32'(sif.sys_addr), 32'(eaddr));
    chk("grant_latency", 32'(waited), 32'd0);
    chk("busy_in_issue", 32'(busy), 32'd1);

    stable = 1'b1;
    for (int i = 0; i < ack_dly; i++) begin
      if (gaps) begin
        sif.sys_rd_data_valid = 1'($urandom_range(1));
        sif.sys_wr_data_valid = 1'($urandom_range(1));
      end
      @(posedge clk); #1;
      if (sif.sys_cmd !== ecmd || sif.sys_addr !== eaddr) stable = 1'b0;
    end
    chk("cmd_held_until_ack", 32'(stable), 32'd1);
    sif.sys_rd_data_valid = 1'b0;
    sif.sys_wr_data_valid = 1'b0;
    sif.sys_cmd_ack = ecmd;
    @(posedge clk); #1;
    sif.sys_cmd_ack = 2'b00;
    chk("cmd_nop_after_ack", 32'(sif.sys_cmd), 32'd0);
    if (ecmd == 2'b10) m_vid = (m_vid + 1) % c_VID_BURSTS;
    chk("vid_addr_after_ack", 32'(vid_addr), 32'(m_vid));

    beats = (ecmd == 2'b10) ? c_VID_BEATS : c_LINE_BEATS;
    n = 0;
    low = '0;
    while (n < beats) begin
      sif.sys_rd_data_valid = 1'b0;
      sif.sys_wr_data_valid = 1'b0;
      vid_restart = 1'b0;
      if (gaps && $urandom_range(3) == 0) begin
        if (ecmd == 2'b01) sif.sys_rd_data_valid = 1'b1;
        else               sif.sys_wr_data_valid = 1'b1;
        sif.sys_dout = 16'($urandom);
      end else begin
        d = seq_data ? 16'(n + 1) : 16'($urandom);
        sif.sys_dout = d;
        if (ecmd == 2'b01) sif.sys_wr_data_valid = 1'b1;
        else               sif.sys_rd_data_valid = 1'b1;
        if (ecmd == 2'b10) begin
          if (n % 2 == 0) low = d;
          else            vq_exp.push_back({d, low});
        end
        if (restart_mid && n == 3) vid_restart = 1'b1;
        if (n == rst_beat) begin
          rst = 1'b0;
          #1;
          chk("rst_sys_cmd", 32'(sif.sys_cmd), 32'd0);
          chk("rst_busy", 32'(busy), 32'd0);
          chk("rst_cache_wdata_en", 32'(cache_wdata_en), 32'd0);
          chk("rst_cache_rdata_en", 32'(cache_rdata_en), 32'd0);
          chk("rst_vid_addr", 32'(vid_addr), 32'd0);
          @(negedge clk);
          sif.sys_rd_data_valid = 1'b0;
          sif.sys_wr_data_valid = 1'b0;
          @(negedge clk);
          rst = 1'b1;
          m_vid = 0;
          m_streak = 0;
          #1;
          return;
        end
        n++;
      end
      @(posedge clk); #1;
    end
    sif.sys_rd_data_valid = 1'b0;
    sif.sys_wr_data_valid = 1'b0;
    vid_restart = 1'b0;
    chk("idle_after_last_beat", 32'(busy), 32'd0);
    if (restart_mid) m_vid = 0;

    @(negedge clk); #1;
    chk("vq_wr_pulses", 32'(vq_cnt - vq0), 32'((ecmd == 2'b10) ? beats / 2 : 0));
    chk("cache_wdata_en_pulses", 32'(cw_cnt - cw0), 32'((ecmd == 2'b11) ? beats : 0));
    chk("cache_rdata_en_pulses", 32'(cr_cnt - cr0), 32'((ecmd == 2'b01) ? beats : 0));
    for (int i = 0; i < vq_exp.size(); i++) begin
      chk("vq_data_word", vq_got[q0 + i], vq_exp[i]);
    end
    chk("vid_addr_end", 32'(vid_addr), 32'(m_vid));
  endtask

  initial begin
    int q;
    int guard;
    sif.sys_cmd_ack       = 2'b00;
    sif.sys_rd_data_valid = 1'b0;
    sif.sys_wr_data_valid = 1'b0;
    sif.sys_dout          = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sys_cmd", 32'(sif.sys_cmd), 32'd0);
    chk("reset_sys_addr", 32'(sif.sys_addr), 32'd0);
    chk("reset_vid_addr", 32'(vid_addr), 32'd0);
    chk("reset_vq_wr", 32'(vq_wr), 32'd0);
    chk("reset_vq_data", vq_data, 32'd0);
    chk("reset_cache_wdata_en", 32'(cache_wdata_en), 32'd0);
    chk("reset_cache_rdata_en", 32'(cache_rdata_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;

    // no requests: nothing issued
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_cmd", 32'(sif.sys_cmd), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);

    // video only, sequential data 0x0001..0x0010, ack after 3 cycles
    vid_need = 1'b1;
    q = vq_got.size();
    txn(3, 1'b0, 1'b1, 1'b0, -1);
    chk("first_vq_word", vq_got[q], 32'h00020001);
    chk("vid_addr_after_first", 32'(vid_addr), 32'd1);
    vid_need = 1'b0;

    // restart in IDLE clears the address at once
    vid_restart = 1'b1;
    @(posedge clk); #1;
    vid_restart = 1'b0;
    m_vid = 0;
    chk("restart_idle_vid_addr", 32'(vid_addr), 32'd0);

    // simultaneous write-back and fill: write-back first
    wb_addr = 12'h123; fill_addr = 12'h456;
    cache_wr_req = 1'b1; cache_rd_req = 1'b1;
    txn(2, 1'b1, 1'b0, 1'b0, -1);
    cache_wr_req = 1'b0;
    txn(1, 1'b1, 1'b0, 1'b0, -1);
    cache_rd_req = 1'b0;

    // deferred restart during a video burst at vid_addr 5
    vid_need = 1'b1;
    guard = 0;
    while (m_vid != 5 && guard < 10) begin
      txn(0, 1'b0, 1'b0, 1'b0, -1);
      guard++;
    end
    txn(1, 1'b1, 1'b0, 1'b1, -1);
    chk("restart_deferred_vid_addr", 32'(vid_addr), 32'd0);
    txn(0, 1'b0, 1'b0, 1'b0, -1);

    // video held with a pending fill: strict priority or fairness
    cache_rd_req = 1'b1;
    fill_addr = 12'($urandom);
    repeat (6) txn(0, 1'b1, 1'b0, 1'b0, -1);
    cache_rd_req = 1'b0;
    vid_need = 1'b0;

    // randomized request mix
    repeat (16) begin
      vid_need     = 1'($urandom_range(1));
      cache_wr_req = 1'($urandom_range(1));
      cache_rd_req = 1'($urandom_range(1));
      if (!(vid_need | cache_wr_req | cache_rd_req)) cache_rd_req = 1'b1;
      wb_addr   = 12'($urandom);
      fill_addr = 12'($urandom);
      txn(int'($urandom_range(4)), 1'b1, 1'b0, 1'b0, -1);
    end
    vid_need = 1'b0; cache_wr_req = 1'b0; cache_rd_req = 1'b0;

    // frame address wrap
    vid_need = 1'b1;
    guard = 0;
    while (m_vid != c_VID_BURSTS - 1 && guard < c_VID_BURSTS + 2) begin
      txn(0, 1'b0, 1'b0, 1'b0, -1);
      guard++;
    end
    txn(0, 1'b0, 1'b0, 1'b0, -1);
    chk("wrap_vid_addr", 32'(vid_addr), 32'd0);
    txn(0, 1'b0, 1'b0, 1'b0, -1);
    vid_need = 1'b0;

    // reset in the middle of a fill, then a fresh grant
    fill_addr = 12'h2AB;
    cache_rd_req = 1'b1;
    txn(1, 1'b0, 1'b0, 1'b0, 40);
    txn(0, 1'b1, 1'b0, 1'b0, -1);
    cache_rd_req = 1'b0;

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_cmd_sched.md
# sdram_cmd_sched

Command scheduler between the SDRAM_16bit controller and its two clients: the video refill path and the cache line-fill/write-back path. Runs in the SDRAM clock domain. Arbitrates requests, holds one command until it is acknowledged, and counts data beats to find the end of each burst. Routes read beats to the cache strobes or packs them into 32-bit words for the video queue, and owns the wrapping video frame address.

## Interface
Parameters:
- VID_BURSTS, 3072: video bursts (32 bytes each) per frame; the address wraps after VID_BURSTS-1.
- VID_BEATS, 16: 16-bit beats per video burst.
- LINE_BEATS, 128: 16-bit beats per cache burst (256 bytes).
- MAX_VID, 4: consecutive video grants allowed while cache waits (only used with SDR_FAIRNESS_EN).

Ports (one clock; reset is asynchronous and active-low):
- clk in 1: SDRAM clock (clk_sdr).
- rst in 1: async active-low reset.
- vid_need in 1: video queue almost empty.
- vid_restart in 1: one-cycle pulse, synchronised vsync edge; realigns the frame address.
- cache_wr_req in 1: dirty line must be written back.
- cache_rd_req in 1: line fill requested.
- wb_addr in 12: write-back line address.
- fill_addr in 12: fill line address.
- sys_cmd out 2: 00 nop, 01 write 256 B, 10 read 32 B, 11 read 256 B.
- sys_addr out 18: word address for sys_cmd.
- sys_cmd_ack in 2: controller acknowledge (echoes accepted command).
- sys_rd_data_valid in 1, sys_wr_data_valid in 1: per-beat strobes.
- sys_dout in 16: read data.
- cache_wdata_en out 1: cache_write_data (read beat belongs to cache).
- cache_rdata_en out 1: cache_read_data (write beat sourced from cache).
- vq_data out 32, vq_wr out 1: video queue write port.
- vid_addr out 12: current video burst index.
- busy out 1: state is not IDLE.

## Operation
- States: IDLE, ISSUE, XFER.
- IDLE: evaluate requests; grant order is video > write-back > fill. On a grant, register sys_cmd and sys_addr, latch the owner, and go to ISSUE.
- Addresses:
  - Video: {3'b100, vid_addr, 3'b000}.
  - Write-back: {wb_addr, 6'b0}.
  - Fill: {fill_addr, 6'b0}.
- ISSUE: hold sys_cmd/sys_addr stable until sys_cmd_ack == sys_cmd. Then drive sys_cmd=00, clear the beat counter and go to XFER.
  - A video ack advances vid_addr: VID_BURSTS-1 wraps to 0, otherwise +1.
- XFER, video owner:
  - Each sys_rd_data_valid beat toggles the half flag.
  - Even beat stores sys_dout in the low half.
  - Odd beat drives vq_data={sys_dout, low}, vq_wr=1 for one cycle.
- XFER, cache owner:
  - cache_wdata_en = sys_rd_data_valid (fill).
  - cache_rdata_en = sys_wr_data_valid (write-back).
  - Both are combinational pass-through, gated by owner.
- Burst end: the beat counter reaches VID_BEATS or LINE_BEATS; go back to IDLE.
- Strobes of the wrong type, or arriving in IDLE/ISSUE, are ignored (no output pulse).
- vid_restart in IDLE/ISSUE-for-cache clears vid_addr immediately. During a video ISSUE/XFER it is deferred: vid_addr becomes 0 after that burst ends, not vid_addr+1.
- Requests are levels, sampled only in IDLE. A request dropped during ISSUE does not abort the command.
- Reset mid-burst: return to IDLE and drop all strobes. The controller is reset by the same rst.

## Timing
- Reset values:
  - sys_cmd=00, sys_addr=0, vid_addr=0.
  - vq_wr=0, vq_data=0, cache_wdata_en=0, cache_rdata_en=0, busy=0.
  - State IDLE, half flag 0.
- Request seen in IDLE at cycle n: sys_cmd valid at n+1.
- Ack at cycle m: sys_cmd=00 at m+1.
- vq_wr pulses the cycle after each odd read beat: 8 pulses per video burst.
- Last beat at cycle k: IDLE at k+1, next grant's sys_cmd at k+2.
- Write-back and fill requested simultaneously: write-back first, so a dirty victim is written before its fill.

## Configuration
- SDR_FAIRNESS_EN defined:
  - Counts consecutive video grants made while a cache request is pending.
  - After MAX_VID, the next IDLE grant goes to cache even if vid_need=1.
  - The counter clears on any cache grant or when no cache request is pending.
- Undefined: strict priority video > write-back > fill; no counter logic.

## Test plan
- Video only: vid_need=1, ack after 3 cycles, 16 beats 0x0001..0x0010 -> sys_cmd=10, sys_addr=0x20000, vq_wr ×8, first vq_data=0x00020001, vid_addr=1.
- Wrap: vid_addr preset to 3071 via 3071 bursts, one more ack -> vid_addr=0, next sys_addr=0x20000.
- Simultaneous wr+rd, wb_addr=0x123, fill_addr=0x456 -> 01/0x048C0 first, 128 cache_rdata_en pulses; then 11/0x11580 with 128 cache_wdata_en pulses.
- vid_restart during video XFER at vid_addr=5 -> burst completes with 8 vq_wr pulses, then vid_addr=0.
- rst low mid-XFER (beat 40 of 128) -> sys_cmd=00, strobes 0, busy=0 immediately; after release, fresh grant.
- SDR_FAIRNESS_EN, vid_need held 1, cache_rd_req=1 -> 4 video grants, then one 11 grant, then video resumes; without the macro, cache never granted.
